// File: rtl/grf_wb_issuer.sv
// Register-file writeback issuer: merges a fire-and-forget pipeline source with a
// queued multi-cycle-unit source onto one registered GRF write port.
module grf_wb_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    input  logic [4:0]  s0_addr,
    input  logic [31:0] s0_data,
    input  logic [31:0] s0_pc,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_addr,
    input  logic [31:0] s1_data,
    input  logic [31:0] s1_pc,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    input  logic [4:0]  q_addr,
    output logic        q_busy,
    output logic [31:0] issued_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             grf_we_q, grf_we_d;
    logic [4:0]       grf_a3_q, grf_a3_d;
    logic [31:0]      grf_wd_q, grf_wd_d;
    logic [31:0]      grf_pc_q, grf_pc_d;
    logic [31:0]      issued_q, issued_d;

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] scan_idx;

    // Ready looks only at the registered count, so a full queue refuses even when popping.
    assign s1_ready = (count_q < CNT_W'(DEPTH));

    always_comb begin
        push     = s1_valid && s1_ready;
        pop      = !s0_valid && (count_q != '0);
        grf_we_d = 1'b0;
        grf_a3_d = grf_a3_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (s0_valid) begin
            grf_we_d = (s0_addr != 5'd0);
            grf_a3_d = s0_addr;
            grf_wd_d = s0_data;
            grf_pc_d = s0_pc;
        end else if (pop) begin
            grf_we_d = (fifo_addr_q[rd_ptr_q] != 5'd0);
            grf_a3_d = fifo_addr_q[rd_ptr_q];
            grf_wd_d = fifo_data_q[rd_ptr_q];
            grf_pc_d = fifo_pc_q[rd_ptr_q];
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        issued_d = grf_we_d ? (issued_q + 32'd1) : issued_q;
    end

    // Hazard query: scan only the occupied slots, starting at the head.
    always_comb begin
        q_busy   = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[scan_idx] == q_addr)) begin
                q_busy = 1'b1;
            end
        end
        if (grf_we_q && (grf_a3_q == q_addr)) begin
            q_busy = 1'b1;
        end
        if (q_addr == 5'd0) begin
            q_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            grf_we_q <= 1'b0;
            grf_a3_q <= 5'd0;
            grf_wd_q <= 32'd0;
            grf_pc_q <= 32'd0;
            issued_q <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            grf_we_q <= grf_we_d;
            grf_a3_q <= grf_a3_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_addr_q[wr_ptr_q] <= s1_addr;
            fifo_data_q[wr_ptr_q] <= s1_data;
            fifo_pc_q[wr_ptr_q]   <= s1_pc;
        end
    end

    assign grf_we     = grf_we_q;
    assign grf_a3     = grf_a3_q;
    assign grf_wd     = grf_wd_q;
    assign grf_pc     = grf_pc_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_grf_wb_issuer.sv
// Directed bench for grf_wb_issuer: each task drives one scenario and checks
// the registered write port, ready, hazard query and issue counter inline.
module tb_grf_wb_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s0_valid = 1'b0;
    logic [4:0]  s0_addr = 5'd0;
    logic [31:0] s0_data = 32'd0;
    logic [31:0] s0_pc = 32'd0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [4:0]  s1_addr = 5'd0;
    logic [31:0] s1_data = 32'd0;
    logic [31:0] s1_pc = 32'd0;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q_addr = 5'd0;
    logic        q_busy;
    logic [31:0] issued_cnt;

    int vecs = 0;
    int errs = 0;
    logic [31:0] expCnt = 32'd0;

    grf_wb_issuer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_pc(s0_pc),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_addr(s1_addr), .s1_data(s1_data), .s1_pc(s1_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_addr(q_addr), .q_busy(q_busy), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        q_addr = 5'd5;
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL rst_we got %0h exp 0", grf_we); end
        vecs++; if (grf_a3 !== 5'd0) begin errs++; $display("[TB] FAIL rst_a3 got %0h exp 0", grf_a3); end
        vecs++; if (grf_wd !== 32'd0) begin errs++; $display("[TB] FAIL rst_wd got %0h exp 0", grf_wd); end
        vecs++; if (grf_pc !== 32'd0) begin errs++; $display("[TB] FAIL rst_pc got %0h exp 0", grf_pc); end
        vecs++; if (issued_cnt !== 32'd0) begin errs++; $display("[TB] FAIL rst_cnt got %0h exp 0", issued_cnt); end
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("[TB] FAIL rst_ready got %0h exp 1", s1_ready); end
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL rst_qbusy got %0h exp 0", q_busy); end
        reset = 1'b0;
        expCnt = 32'd0;
    endtask

    task automatic test_s0_path();
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h1234; s0_pc = 32'h3000;
        @(negedge clk);
        s0_valid = 1'b0;
        expCnt = expCnt + 32'd1;
        q_addr = 5'd5;
        #1;
        vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL s0_we got %0h exp 1", grf_we); end
        vecs++; if (grf_a3 !== 5'd5) begin errs++; $display("[TB] FAIL s0_a3 got %0h exp 5", grf_a3); end
        vecs++; if (grf_wd !== 32'h1234) begin errs++; $display("[TB] FAIL s0_wd got %0h exp 1234", grf_wd); end
        vecs++; if (grf_pc !== 32'h3000) begin errs++; $display("[TB] FAIL s0_pc got %0h exp 3000", grf_pc); end
        vecs++; if (issued_cnt !== 32'd1) begin errs++; $display("[TB] FAIL s0_cnt got %0h exp 1", issued_cnt); end
        vecs++; if (q_busy !== 1'b1) begin errs++; $display("[TB] FAIL s0_qbusy got %0h exp 1", q_busy); end
        @(negedge clk);
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL s0_idle_we got %0h exp 0", grf_we); end
        vecs++; if (grf_a3 !== 5'd5) begin errs++; $display("[TB] FAIL s0_hold_a3 got %0h exp 5", grf_a3); end
        vecs++; if (grf_wd !== 32'h1234) begin errs++; $display("[TB] FAIL s0_hold_wd got %0h exp 1234", grf_wd); end
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL s0_idle_qbusy got %0h exp 0", q_busy); end
    endtask

    task automatic test_s1_path();
        s1_valid = 1'b1; s1_addr = 5'd8; s1_data = 32'hABCD; s1_pc = 32'h4000;
        #1;
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("[TB] FAIL s1_ready got %0h exp 1", s1_ready); end
        @(negedge clk);
        s1_valid = 1'b0;
        q_addr = 5'd8;
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL s1_nobypass_we got %0h exp 0", grf_we); end
        vecs++; if (q_busy !== 1'b1) begin errs++; $display("[TB] FAIL s1_queued_qbusy got %0h exp 1", q_busy); end
        @(negedge clk);
        expCnt = expCnt + 32'd1;
        #1;
        vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL s1_we got %0h exp 1", grf_we); end
        vecs++; if (grf_a3 !== 5'd8) begin errs++; $display("[TB] FAIL s1_a3 got %0h exp 8", grf_a3); end
        vecs++; if (grf_wd !== 32'hABCD) begin errs++; $display("[TB] FAIL s1_wd got %0h exp abcd", grf_wd); end
        vecs++; if (grf_pc !== 32'h4000) begin errs++; $display("[TB] FAIL s1_pc got %0h exp 4000", grf_pc); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL s1_cnt got %0h exp %0h", issued_cnt, expCnt); end
        @(negedge clk);
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL s1_drained_we got %0h exp 0", grf_we); end
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL s1_drained_qbusy got %0h exp 0", q_busy); end
    endtask

    task automatic test_priority_fill();
        for (int cyc = 0; cyc < 6; cyc++) begin
            s0_valid = 1'b1;
            s0_addr  = 5'(1 + cyc);
            s0_data  = 32'h100 + 32'(cyc);
            s0_pc    = 32'h5000 + 32'(cyc);
            s1_valid = 1'b1;
            s1_addr  = (cyc < 4) ? 5'(10 + cyc) : 5'd14;
            s1_data  = (cyc < 4) ? 32'h200 + 32'(cyc) : 32'h204;
            s1_pc    = (cyc < 4) ? 32'h6000 + 32'(cyc) : 32'h6004;
            #1;
            vecs++; if (s1_ready !== (cyc < 4)) begin errs++; $display("[TB] FAIL fill_ready[%0d] got %0h exp %0h", cyc, s1_ready, (cyc < 4)); end
            @(negedge clk);
            expCnt = expCnt + 32'd1;
            #1;
            vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL fill_we[%0d] got %0h exp 1", cyc, grf_we); end
            vecs++; if (grf_a3 !== 5'(1 + cyc)) begin errs++; $display("[TB] FAIL fill_a3[%0d] got %0h exp %0h", cyc, grf_a3, 1 + cyc); end
            vecs++; if (grf_wd !== 32'h100 + 32'(cyc)) begin errs++; $display("[TB] FAIL fill_wd[%0d] got %0h exp %0h", cyc, grf_wd, 32'h100 + cyc); end
        end
        idle_inputs();
        q_addr = 5'd13;
        #1;
        vecs++; if (q_busy !== 1'b1) begin errs++; $display("[TB] FAIL fill_qbusy13 got %0h exp 1", q_busy); end
        q_addr = 5'd14;
        #1;
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL fill_qbusy14 got %0h exp 0", q_busy); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            expCnt = expCnt + 32'd1;
            #1;
            vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL drain_we[%0d] got %0h exp 1", j, grf_we); end
            vecs++; if (grf_a3 !== 5'(10 + j)) begin errs++; $display("[TB] FAIL drain_a3[%0d] got %0h exp %0h", j, grf_a3, 10 + j); end
            vecs++; if (grf_wd !== 32'h200 + 32'(j)) begin errs++; $display("[TB] FAIL drain_wd[%0d] got %0h exp %0h", j, grf_wd, 32'h200 + j); end
            vecs++; if (grf_pc !== 32'h6000 + 32'(j)) begin errs++; $display("[TB] FAIL drain_pc[%0d] got %0h exp %0h", j, grf_pc, 32'h6000 + j); end
        end
        @(negedge clk);
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL drain_done_we got %0h exp 0", grf_we); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL fill_cnt got %0h exp %0h", issued_cnt, expCnt); end
    endtask

    task automatic test_reg0();
        s0_valid = 1'b1; s0_addr = 5'd0; s0_data = 32'hDEAD; s0_pc = 32'h7000;
        @(negedge clk);
        s0_valid = 1'b0;
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL r0_s0_we got %0h exp 0", grf_we); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL r0_s0_cnt got %0h exp %0h", issued_cnt, expCnt); end
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hBEEF; s1_pc = 32'h7004;
        @(negedge clk);
        s1_addr = 5'd9; s1_data = 32'h99; s1_pc = 32'h7008;
        q_addr = 5'd0;
        #1;
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL r0_qbusy0 got %0h exp 0", q_busy); end
        @(negedge clk);
        s1_valid = 1'b0;
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL r0_s1_we got %0h exp 0", grf_we); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL r0_s1_cnt got %0h exp %0h", issued_cnt, expCnt); end
        @(negedge clk);
        expCnt = expCnt + 32'd1;
        #1;
        vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL r0_next_we got %0h exp 1", grf_we); end
        vecs++; if (grf_a3 !== 5'd9) begin errs++; $display("[TB] FAIL r0_next_a3 got %0h exp 9", grf_a3); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL r0_next_cnt got %0h exp %0h", issued_cnt, expCnt); end
        @(negedge clk);
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL r0_drained_we got %0h exp 0", grf_we); end
    endtask

    task automatic test_reset_mid();
        for (int cyc = 0; cyc < 3; cyc++) begin
            s0_valid = 1'b1; s0_addr = 5'(20 + cyc); s0_data = 32'h300 + 32'(cyc); s0_pc = 32'h8000;
            s1_valid = 1'b1; s1_addr = 5'(15 + cyc); s1_data = 32'h400 + 32'(cyc); s1_pc = 32'h9000;
            @(negedge clk);
        end
        s0_valid = 1'b0;
        s1_addr = 5'd18;
        reset = 1'b1;
        q_addr = 5'd15;
        #1;
        vecs++; if (q_busy !== 1'b1) begin errs++; $display("[TB] FAIL rm_pre_qbusy got %0h exp 1", q_busy); end
        @(negedge clk);
        reset = 1'b0;
        s1_valid = 1'b0;
        expCnt = 32'd0;
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL rm_we got %0h exp 0", grf_we); end
        vecs++; if (s1_ready !== 1'b1) begin errs++; $display("[TB] FAIL rm_ready got %0h exp 1", s1_ready); end
        vecs++; if (issued_cnt !== 32'd0) begin errs++; $display("[TB] FAIL rm_cnt got %0h exp 0", issued_cnt); end
        vecs++; if (q_busy !== 1'b0) begin errs++; $display("[TB] FAIL rm_qbusy got %0h exp 0", q_busy); end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            #1;
            vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL rm_lost_we[%0d] got %0h exp 0", j, grf_we); end
        end
        vecs++; if (issued_cnt !== 32'd0) begin errs++; $display("[TB] FAIL rm_final_cnt got %0h exp 0", issued_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 2; cyc++) begin
            s0_valid = 1'b1; s0_addr = 5'(28 + cyc); s0_data = 32'h500; s0_pc = 32'hA000;
            s1_valid = 1'b1; s1_addr = 5'(24 + cyc); s1_data = 32'h600 + 32'(cyc); s1_pc = 32'hB000;
            @(negedge clk);
            expCnt = expCnt + 32'd1;
        end
        s0_valid = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            s1_addr = 5'(26 + cyc); s1_data = 32'h600 + 32'(2 + cyc);
            #1;
            vecs++; if (s1_ready !== 1'b1) begin errs++; $display("[TB] FAIL bb_ready[%0d] got %0h exp 1", cyc, s1_ready); end
            @(negedge clk);
            expCnt = expCnt + 32'd1;
            #1;
            vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL bb_we[%0d] got %0h exp 1", cyc, grf_we); end
            vecs++; if (grf_a3 !== 5'(24 + cyc)) begin errs++; $display("[TB] FAIL bb_a3[%0d] got %0h exp %0h", cyc, grf_a3, 24 + cyc); end
        end
        s1_valid = 1'b0;
        q_addr = 5'd27;
        #1;
        vecs++; if (q_busy !== 1'b1) begin errs++; $display("[TB] FAIL bb_qbusy27 got %0h exp 1", q_busy); end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            expCnt = expCnt + 32'd1;
            #1;
            vecs++; if (grf_we !== 1'b1) begin errs++; $display("[TB] FAIL bb_drain_we[%0d] got %0h exp 1", j, grf_we); end
            vecs++; if (grf_a3 !== 5'(26 + j)) begin errs++; $display("[TB] FAIL bb_drain_a3[%0d] got %0h exp %0h", j, grf_a3, 26 + j); end
            vecs++; if (grf_wd !== 32'h600 + 32'(2 + j)) begin errs++; $display("[TB] FAIL bb_drain_wd[%0d] got %0h exp %0h", j, grf_wd, 32'h602 + j); end
        end
        @(negedge clk);
        #1;
        vecs++; if (grf_we !== 1'b0) begin errs++; $display("[TB] FAIL bb_empty_we got %0h exp 0", grf_we); end
        vecs++; if (issued_cnt !== expCnt) begin errs++; $display("[TB] FAIL bb_cnt got %0h exp %0h", issued_cnt, expCnt); end
    endtask

    initial begin
        test_reset();
        test_s0_path();
        test_s1_path();
        test_priority_fill();
        test_reg0();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
